draw_paddle: RTL and testbench

Parametrised paddle renderer and position controller for either side of the Pong field. It sits in the `vga_if` pixel pipeline between background/ball drawing and the output stage, and overlays a solid paddle rectangle. Paddle motion runs once per frame and has four modes: hold, AI ball-tracking with a dead zone and speed limit, player buttons, and glide-to-centre. The paddle position is clamped to the visible field.

---
 rtl/pong_pkg.sv | 26 ++
 rtl/vga_pkg.sv | 9 +
 rtl/vga_if.sv | 18 +
 rtl/paddle_ctl.sv | 152 +++++++++++++++
 rtl/draw_paddle.sv | 85 ++++++++
 tb/tb_draw_paddle.sv | 327 ++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/pong_pkg.sv
// pong_pkg: paddle modes, paddle geometry/motion defaults and a saturating subtract.
package pong_pkg;

    typedef enum logic [1:0] {
        PADDLE_HOLD   = 2'd0,
        PADDLE_AI     = 2'd1,
        PADDLE_PLAYER = 2'd2,
        PADDLE_CENTER = 2'd3
    } paddle_mode_t;

    localparam int unsigned PADDLE_H         = 100;
    localparam int unsigned PADDLE_W         = 15;
    localparam int unsigned PADDLE_SPEED     = 4;
    localparam int unsigned PADDLE_DEAD_ZONE = 8;
    localparam logic [11:0] PADDLE_COLOR     = 12'hfff;

    // Motion arithmetic width: wide enough for y + SPEED and centre + dead zone.
    localparam int unsigned MOTION_W = 12;

    // a - b, floored at zero instead of wrapping.
    function automatic logic [MOTION_W-1:0] sat_sub(input logic [MOTION_W-1:0] a,
                                                    input logic [MOTION_W-1:0] b);
        return (a > b) ? (a - b) : '0;
    endfunction

endpackage : pong_pkg

// File: rtl/vga_pkg.sv
// vga_pkg: visible-field geometry and pixel-bus widths shared by the VGA pipeline.
package vga_pkg;

    localparam int unsigned HOR_PIXELS = 1024;
    localparam int unsigned VER_PIXELS = 768;
    localparam int unsigned COORD_W    = 11;
    localparam int unsigned RGB_W      = 12;

endpackage : vga_pkg

// File: rtl/vga_if.sv
// vga_if: one pixel-pipeline stage (timing counters, syncs, blanks, rgb).
//   modport in  : consumer view, all fields input
//   modport out : producer view, all fields output
interface vga_if;
    import vga_pkg::*;

    logic [COORD_W-1:0] hcount;
    logic [COORD_W-1:0] vcount;
    logic               hsync;
    logic               vsync;
    logic               hblnk;
    logic               vblnk;
    logic [RGB_W-1:0]   rgb;

    modport in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface : vga_if

// File: rtl/paddle_ctl.sv
// paddle_ctl: per-frame paddle position controller.
//   clk, rst_n     : pixel clock, async active-low reset
//   vblnk          : upstream vertical blank; its rising edge is the frame tick
//   mode           : motion mode, latched at the tick
//   btn_up/down    : player buttons (level)
//   ball_y_pos     : ball top row for AI tracking
//   y_position     : registered paddle top row, changes two cycles after the tick
module paddle_ctl
    import pong_pkg::*;
    import vga_pkg::*;
#(
    parameter int unsigned HEIGHT    = PADDLE_H,
    parameter int unsigned SPEED     = PADDLE_SPEED,
    parameter int unsigned DEAD_ZONE = PADDLE_DEAD_ZONE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               vblnk,
    input  paddle_mode_t       mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [COORD_W-1:0] ball_y_pos,
    output logic [COORD_W-1:0] y_position
);

    localparam int unsigned Y_MAX    = VER_PIXELS - HEIGHT;
    localparam int unsigned Y_CENTER = Y_MAX / 2;

    localparam logic [MOTION_W-1:0] Y_MAX_M    = MOTION_W'(Y_MAX);
    localparam logic [MOTION_W-1:0] Y_CENTER_M = MOTION_W'(Y_CENTER);
    localparam logic [MOTION_W-1:0] HALF_H_M   = MOTION_W'(HEIGHT / 2);
    localparam logic [MOTION_W-1:0] SPEED_M    = MOTION_W'(SPEED);
    localparam logic [MOTION_W-1:0] DZ_M       = MOTION_W'(DEAD_ZONE);

    localparam logic [1:0] ST_WAIT_TICK = 2'd0;
    localparam logic [1:0] ST_COMPUTE   = 2'd1;
    localparam logic [1:0] ST_COMMIT    = 2'd2;

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic                vblnk_d;
    logic                tick;
    logic                latch_mode;
    logic                load_cand;
    logic                commit;
    paddle_mode_t        mode_q;
    logic [MOTION_W-1:0] cand_q;
    logic [MOTION_W-1:0] cand;
    logic [MOTION_W-1:0] y_m;
    logic [MOTION_W-1:0] ctr_m;
    logic [MOTION_W-1:0] ball_m;
    logic [MOTION_W-1:0] y_inc;
    logic [MOTION_W-1:0] y_dec;
    logic [MOTION_W-1:0] ctr_dist;

    // vblnk_d resets high so a release during vblank does not look like an edge.
    assign tick = vblnk & ~vblnk_d;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_TICK;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and datapath strobes; ticks outside WAIT_TICK are dropped.
    always_comb begin
        state_nxt  = state;
        latch_mode = 1'b0;
        load_cand  = 1'b0;
        commit     = 1'b0;
        case (state)
            ST_WAIT_TICK: begin
                if (tick) begin
                    latch_mode = 1'b1;
                    state_nxt  = ST_COMPUTE;
                end
            end
            ST_COMPUTE: begin
                load_cand = 1'b1;
                state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                commit    = 1'b1;
                state_nxt = ST_WAIT_TICK;
            end
            default: state_nxt = ST_WAIT_TICK;
        endcase
    end

    // Candidate position for the latched mode, before the upper clamp.
    always_comb begin
        y_m      = MOTION_W'(y_position);
        ctr_m    = y_m + HALF_H_M;
        ball_m   = MOTION_W'(ball_y_pos);
        y_inc    = y_m + SPEED_M;
        y_dec    = sat_sub(y_m, SPEED_M);
        ctr_dist = (y_m >= Y_CENTER_M) ? (y_m - Y_CENTER_M) : (Y_CENTER_M - y_m);
        cand     = y_m;
        case (mode_q)
            PADDLE_AI: begin
                // Lower-side compare adds to the ball rather than subtracting from c.
                if (ball_m > ctr_m + DZ_M) begin
                    cand = y_inc;
                end else if (ball_m + DZ_M < ctr_m) begin
                    cand = y_dec;
                end
            end
            PADDLE_PLAYER: begin
                if (btn_up && !btn_down) begin
                    cand = y_dec;
                end else if (btn_down && !btn_up) begin
                    cand = y_inc;
                end
            end
            PADDLE_CENTER: begin
                if (ctr_dist <= SPEED_M) begin
                    cand = Y_CENTER_M;
                end else if (y_m > Y_CENTER_M) begin
                    cand = y_dec;
                end else begin
                    cand = y_inc;
                end
            end
            default: cand = y_m;
        endcase
    end

    // Edge detect, mode latch, candidate register and clamped commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d    <= 1'b1;
            mode_q     <= PADDLE_HOLD;
            cand_q     <= Y_CENTER_M;
            y_position <= COORD_W'(Y_CENTER);
        end else begin
            vblnk_d <= vblnk;
            if (latch_mode) begin
                mode_q <= mode;
            end
            if (load_cand) begin
                cand_q <= cand;
            end
            if (commit) begin
                y_position <= COORD_W'((cand_q > Y_MAX_M) ? Y_MAX_M : cand_q);
            end
        end
    end

endmodule : paddle_ctl

// File: rtl/draw_paddle.sv
// draw_paddle: overlays a solid paddle rectangle on the VGA pixel stream.
//   clk, rst_n        : pixel clock, async active-low reset
//   mode, btn_up/down : paddle motion control (see paddle_ctl)
//   ball_y_pos        : ball top row for AI tracking
//   y_position        : current paddle top row
//   vga / vga_out     : pixel pipeline in / out, one register stage
module draw_paddle
    import pong_pkg::*;
    import vga_pkg::*;
#(
    parameter int unsigned X_POS     = HOR_PIXELS - 30,
    parameter int unsigned WIDTH     = PADDLE_W,
    parameter int unsigned HEIGHT    = PADDLE_H,
    parameter logic [11:0] COLOR     = PADDLE_COLOR,
    parameter int unsigned SPEED     = PADDLE_SPEED,
    parameter int unsigned DEAD_ZONE = PADDLE_DEAD_ZONE
) (
    input  logic               clk,
    input  logic               rst_n,
    input  paddle_mode_t       mode,
    input  logic               btn_up,
    input  logic               btn_down,
    input  logic [COORD_W-1:0] ball_y_pos,
    output logic [COORD_W-1:0] y_position,
    vga_if.in                  vga,
    vga_if.out                 vga_out
);

    localparam logic [MOTION_W-1:0] X_LO_M = MOTION_W'(X_POS);
    localparam logic [MOTION_W-1:0] X_HI_M = MOTION_W'(X_POS + WIDTH - 1);
    localparam logic [MOTION_W-1:0] H_M    = MOTION_W'(HEIGHT);

    logic [MOTION_W-1:0] h_m;
    logic [MOTION_W-1:0] v_m;
    logic [MOTION_W-1:0] y_lo;
    logic [MOTION_W-1:0] y_hi;
    logic                in_paddle;

    // Position controller, updated once per frame inside vblank.
    paddle_ctl #(
        .HEIGHT    (HEIGHT),
        .SPEED     (SPEED),
        .DEAD_ZONE (DEAD_ZONE)
    ) u_ctl (
        .clk        (clk),
        .rst_n      (rst_n),
        .vblnk      (vga.vblnk),
        .mode       (mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .ball_y_pos (ball_y_pos),
        .y_position (y_position)
    );

    // Inclusive rectangle hit test on the current pixel.
    always_comb begin
        h_m       = MOTION_W'(vga.hcount);
        v_m       = MOTION_W'(vga.vcount);
        y_lo      = MOTION_W'(y_position);
        y_hi      = y_lo + H_M - MOTION_W'(1);
        in_paddle = (h_m >= X_LO_M) && (h_m <= X_HI_M) && (v_m >= y_lo) && (v_m <= y_hi);
    end

    // Pipeline stage; blanking is left for the output stage to mask.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_out.hcount <= '0;
            vga_out.vcount <= '0;
            vga_out.hsync  <= 1'b0;
            vga_out.vsync  <= 1'b0;
            vga_out.hblnk  <= 1'b0;
            vga_out.vblnk  <= 1'b0;
            vga_out.rgb    <= '0;
        end else begin
            vga_out.hcount <= vga.hcount;
            vga_out.vcount <= vga.vcount;
            vga_out.hsync  <= vga.hsync;
            vga_out.vsync  <= vga.vsync;
            vga_out.hblnk  <= vga.hblnk;
            vga_out.vblnk  <= vga.vblnk;
            vga_out.rgb    <= in_paddle ? COLOR : vga.rgb;
        end
    end

endmodule : draw_paddle

// File: tb/tb_draw_paddle.sv
module tb_draw_paddle;
    import pong_pkg::*;

    localparam int YMAX = 668;
    localparam int YC   = 334;
    localparam int SPD  = 4;
    localparam int DZ   = 8;
    localparam int PH   = 100;
    localparam int XP   = 994;
    localparam int PW   = 15;

    logic         clk;
    logic         rst_n;
    paddle_mode_t mode;
    logic         btn_up;
    logic         btn_down;
    logic [10:0]  ball_y_pos;
    logic [10:0]  y_position;

    vga_if vga_in ();
    vga_if vga_o ();

    int total;
    int bad;
    int y_model;

    draw_paddle dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .btn_up     (btn_up),
        .btn_down   (btn_down),
        .ball_y_pos (ball_y_pos),
        .y_position (y_position),
        .vga        (vga_in),
        .vga_out    (vga_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: one frame of paddle motion on plain integers.
    function automatic int model_next(int y, paddle_mode_t m, bit up, bit dn, int ball);
        int c;
        int n;
        int d;
        c = y + PH / 2;
        n = y;
        case (m)
            PADDLE_AI: begin
                if (ball > c + DZ) n = y + SPD;
                else if (ball < c - DZ) n = y - SPD;
            end
            PADDLE_PLAYER: begin
                if (up && !dn) n = y - SPD;
                else if (dn && !up) n = y + SPD;
            end
            PADDLE_CENTER: begin
                d = y - YC;
                if (d >= -SPD && d <= SPD) n = YC;
                else if (d > 0) n = y - SPD;
                else n = y + SPD;
            end
            default: n = y;
        endcase
        if (n < 0) n = 0;
        if (n > YMAX) n = YMAX;
        return n;
    endfunction

    task automatic drive_random_pixel();
        vga_in.hcount = 11'($urandom_range(0, 1343));
        vga_in.vcount = 11'($urandom_range(0, 805));
        vga_in.hsync  = 1'($urandom);
        vga_in.vsync  = 1'($urandom);
        vga_in.hblnk  = 1'($urandom);
        vga_in.rgb    = 12'($urandom);
    endtask

    // One frame: blank low, vblnk rise, then check the update lands at tick+2.
    task automatic run_frame(input string tag);
        int exp;
        vga_in.vblnk = 1'b0;
        repeat (3) begin
            @(negedge clk);
            drive_random_pixel();
        end
        exp = model_next(y_model, mode, btn_up, btn_down, int'(ball_y_pos));
        @(negedge clk);
        vga_in.vblnk = 1'b1;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (y_position !== 11'(y_model))
            $display("FAIL %s_early: y_position=%0d expected=%0d", tag, y_position, y_model);
        if (y_position !== 11'(y_model)) bad++;
        @(negedge clk);
        total++;
        if (y_position !== 11'(exp)) begin
            $display("FAIL %s: y_position=%0d expected=%0d", tag, y_position, exp);
            bad++;
        end
        y_model = exp;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            drive_random_pixel();
            vga_in.hcount = 11'd77;
            vga_in.rgb    = 12'h5a5;
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({vga_o.hcount, vga_o.vcount, vga_o.hsync, vga_o.vsync, vga_o.hblnk,
             vga_o.vblnk, vga_o.rgb} !== '0) begin
            $display("FAIL reset_vga_out: hcount=%0d rgb=%h expected all zero", vga_o.hcount, vga_o.rgb);
            bad++;
        end
        total++;
        if (y_position !== 11'(YC)) begin
            $display("FAIL reset_y: y_position=%0d expected=%0d", y_position, YC);
            bad++;
        end
        y_model = YC;
        vga_in.vblnk = 1'b1;
        mode         = PADDLE_AI;
        ball_y_pos   = 11'd2047;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        total++;
        if (y_position !== 11'(YC)) begin
            $display("FAIL reset_release_no_tick: y_position=%0d expected=%0d", y_position, YC);
            bad++;
        end
        run_frame("reset_first_ai");
    endtask

    task automatic test_player();
        mode     = PADDLE_PLAYER;
        btn_up   = 1'b1;
        btn_down = 1'b0;
        for (int i = 0; i < 200 && y_model != 2; i++) run_frame("player_up");
        total++;
        if (y_position !== 11'd2) begin
            $display("FAIL player_reach2: y_position=%0d expected=2", y_position);
            bad++;
        end
        run_frame("player_clamp0");
        run_frame("player_hold0");
        btn_down = 1'b1;
        repeat (3) run_frame("player_both");
        btn_up = 1'b0;
        repeat (5) run_frame("player_down");
    endtask

    task automatic test_center();
        mode     = PADDLE_PLAYER;
        btn_up   = 1'b1;
        btn_down = 1'b0;
        for (int i = 0; i < 200 && y_model != 0; i++) run_frame("center_prep_up");
        btn_up   = 1'b0;
        btn_down = 1'b1;
        repeat (84) run_frame("center_prep_down");
        mode = PADDLE_CENTER;
        run_frame("center_snap336");
        mode     = PADDLE_PLAYER;
        btn_up   = 1'b1;
        btn_down = 1'b0;
        for (int i = 0; i < 200 && y_model != 0; i++) run_frame("center_prep_up2");
        mode = PADDLE_CENTER;
        for (int i = 0; i < 100 && y_model != YC; i++) run_frame("center_glide");
        repeat (2) run_frame("center_settled");
        btn_up = 1'b0;
    endtask

    task automatic test_ai();
        mode       = PADDLE_AI;
        ball_y_pos = 11'(y_model + PH / 2 + 4);
        run_frame("ai_deadzone_hold");
        ball_y_pos = 11'(y_model + PH / 2 + DZ);
        run_frame("ai_deadzone_edge");
        ball_y_pos = 11'd2047;
        for (int i = 0; i < 200 && y_model != YMAX; i++) run_frame("ai_down");
        repeat (2) run_frame("ai_bottom_hold");
        ball_y_pos = 11'd700;
        repeat (10) run_frame("ai_track700");
        ball_y_pos = 11'd0;
        repeat (4) run_frame("ai_up");
        mode = PADDLE_CENTER;
        for (int i = 0; i < 200 && y_model != YC; i++) run_frame("ai_recentre");
    endtask

    task automatic test_draw();
        int ph[6] = '{994, 1008, 993, 1009, 994, 994};
        int pv[6] = '{334, 433, 334, 334, 434, 333};
        int h;
        int v;
        logic [11:0] rin;
        logic [11:0] exp_rgb;
        logic [25:0] exp_tim;
        vga_in.vblnk = 1'b0;
        for (int i = 0; i < 46; i++) begin
            if (i < 6) begin
                h = ph[i];
                v = pv[i];
            end else begin
                h = $urandom_range(XP + PW + 8, XP - 8);
                v = $urandom_range(y_model + PH + 5, y_model - 5);
            end
            rin = 12'($urandom_range(0, 12'hffe));
            @(negedge clk);
            vga_in.hcount = 11'(h);
            vga_in.vcount = 11'(v);
            vga_in.hsync  = 1'($urandom);
            vga_in.vsync  = 1'($urandom);
            vga_in.hblnk  = 1'($urandom);
            vga_in.vblnk  = 1'b0;
            vga_in.rgb    = rin;
            exp_rgb = (h >= XP && h < XP + PW && v >= y_model && v < y_model + PH) ? 12'hfff : rin;
            exp_tim = {11'(h), 11'(v), vga_in.hsync, vga_in.vsync, vga_in.hblnk, 1'b0};
            @(negedge clk);
            total++;
            if (vga_o.rgb !== exp_rgb) begin
                $display("FAIL draw_rgb(%0d,%0d): rgb=%h expected=%h", h, v, vga_o.rgb, exp_rgb);
                bad++;
            end
            total++;
            if ({vga_o.hcount, vga_o.vcount, vga_o.hsync, vga_o.vsync, vga_o.hblnk, vga_o.vblnk} !== exp_tim) begin
                $display("FAIL draw_timing(%0d,%0d): got=%h expected=%h", h, v,
                         {vga_o.hcount, vga_o.vcount, vga_o.hsync, vga_o.vsync, vga_o.hblnk, vga_o.vblnk}, exp_tim);
                bad++;
            end
        end
    endtask

    task automatic test_mode_switch();
        mode       = PADDLE_AI;
        ball_y_pos = 11'd2047;
        run_frame("switch_ai_frame");
        vga_in.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        mode = PADDLE_HOLD;
        repeat (3) @(negedge clk);
        total++;
        if (y_position !== 11'(y_model)) begin
            $display("FAIL switch_midframe: y_position=%0d expected=%0d", y_position, y_model);
            bad++;
        end
        run_frame("switch_hold_tick");
        run_frame("switch_hold_tick2");
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            mode       = paddle_mode_t'($urandom_range(0, 3));
            btn_up     = 1'($urandom);
            btn_down   = 1'($urandom);
            ball_y_pos = 11'($urandom_range(0, 800));
            run_frame("random");
        end
    endtask

    // Reset between tick and commit must leave the centre position, not a half-update.
    task automatic test_reset_abort();
        mode       = PADDLE_AI;
        ball_y_pos = 11'd2047;
        vga_in.vblnk = 1'b0;
        repeat (3) @(negedge clk);
        vga_in.vblnk = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if (y_position !== 11'(YC)) begin
            $display("FAIL abort_reset_y: y_position=%0d expected=%0d", y_position, YC);
            bad++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++;
        if (y_position !== 11'(YC)) begin
            $display("FAIL abort_no_commit: y_position=%0d expected=%0d", y_position, YC);
            bad++;
        end
        y_model = YC;
        run_frame("abort_next_frame");
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        y_model       = YC;
        rst_n         = 1'b0;
        mode          = PADDLE_HOLD;
        btn_up        = 1'b0;
        btn_down      = 1'b0;
        ball_y_pos    = '0;
        vga_in.hcount = '0;
        vga_in.vcount = '0;
        vga_in.hsync  = 1'b0;
        vga_in.vsync  = 1'b0;
        vga_in.hblnk  = 1'b0;
        vga_in.vblnk  = 1'b1;
        vga_in.rgb    = '0;

        test_reset();
        test_player();
        test_center();
        test_ai();
        test_draw();
        test_mode_switch();
        test_random();
        test_reset_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_draw_paddle
